fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decoder.
- Owns the PC and requests words from instruction memory over a req/ready handshake.
- Presents the fetched instruction and PC+4 to decode; opcode is instr[31:26] and funct is instr[5:0].
- Accepts branch/jump redirects and decode stalls, with a one-entry skid buffer so that no fetched word is lost while stalled.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             decode cannot accept; IF/ID holds
//   branch_taken/target, jump/jump_target
//                     redirect requests; branch wins when both are set
//   imem_req/addr     registered request to instruction memory; addr stable while req=1
//   imem_ready/rdata  memory returns rdata in the cycle ready=1
//   if_id_instr/pc4/valid
//                     pipeline register presented to decode
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]  state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] req_addr_q, req_addr_n;
  logic        kill_q, kill_n;
  logic [31:0] buf_instr_q, buf_instr_n;
  logic [31:0] buf_pc4_q, buf_pc4_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc4_q, pc4_n;
  logic        valid_q, valid_n;
  logic        req_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_addr;

  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;
  assign seq_addr = req_addr_q + 32'd4;

  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    req_addr_n  = req_addr_q;
    kill_n      = kill_q;
    buf_instr_n = buf_instr_q;
    buf_pc4_n   = buf_pc4_q;
    instr_n     = instr_q;
    pc4_n       = pc4_q;
    valid_n     = valid_q;

    // No new word this cycle: decode consumed IF/ID, so it turns into a
    // bubble; pc4 is left alone. Overwritten below when a word lands.
    if (!stall) begin
      instr_n = 32'd0;
      valid_n = 1'b0;
    end

    if (redirect) begin
      pc_n    = target;
      instr_n = 32'd0;
      pc4_n   = 32'd0;
      valid_n = 1'b0;
      if (state_q == BUSY && !imem_ready) begin
        // The request cannot be withdrawn; remember to drop its data.
        kill_n = 1'b1;
      end else begin
        kill_n  = 1'b0;
        state_n = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_n    = BUSY;
          req_addr_n = pc_q;
        end
        BUSY: begin
          if (imem_ready) begin
            if (kill_q) begin
              // Stale word from before the redirect; refetch at the target.
              kill_n     = 1'b0;
              req_addr_n = pc_q;
            end else if (!stall || !valid_q) begin
              instr_n    = imem_rdata;
              pc4_n      = seq_addr;
              valid_n    = 1'b1;
              pc_n       = seq_addr;
              req_addr_n = seq_addr;
            end else begin
              // IF/ID is occupied and held: park the word in the skid buffer.
              buf_instr_n = imem_rdata;
              buf_pc4_n   = seq_addr;
              pc_n        = seq_addr;
              state_n     = FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            instr_n = buf_instr_q;
            pc4_n   = buf_pc4_q;
            valid_n = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      kill_q      <= 1'b0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      req_addr_q  <= req_addr_n;
      kill_q      <= kill_n;
      buf_instr_q <= buf_instr_n;
      buf_pc4_q   <= buf_pc4_n;
      instr_q     <= instr_n;
      pc4_q       <= pc4_n;
      valid_q     <= valid_n;
      req_q       <= (state_n == BUSY);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = req_addr_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a fetch/skid-queue model
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;
  bit          scramble = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model: an in-flight flag for the outstanding fetch, a drop flag for a
  // fetch made stale by a redirect, and a queue standing in for the skid.
  bit          m_inflight, m_drop, m_valid;
  logic [31:0] m_pc, m_addr, m_instr, m_pc4;
  logic [63:0] m_skid[$];

  logic [31:0] hold_a;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = scramble ? ({imem_addr[15:0], imem_addr[31:16]} ^ 32'h5A5A_A5A5) : imem_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return scramble ? ({a[15:0], a[31:16]} ^ 32'h5A5A_A5A5) : a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_drop = 0; m_valid = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_skid.delete();
  endtask

  task automatic step(input bit st, input bit rd, input bit bt, input logic [31:0] bta,
                      input bit jp, input logic [31:0] jta, input bit r);
    bit          loaded;
    logic [31:0] w_instr, w_pc4;
    logic [63:0] e;
    rst = r; stall = st; imem_ready = rd;
    branch_taken = bt; branch_target = bta; jump = jp; jump_target = jta;
    loaded = 0;
    if (r) begin
      model_reset();
    end else if (bt || jp) begin
      m_pc = bt ? bta : jta;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
      m_skid.delete();
      if (m_inflight && !rd) m_drop = 1;
      else begin m_inflight = 0; m_drop = 0; end
    end else begin
      if (m_inflight) begin
        if (rd) begin
          if (m_drop) begin
            m_drop = 0; m_addr = m_pc;
          end else begin
            w_instr = memf(m_addr); w_pc4 = m_addr + 32'd4; m_pc = w_pc4;
            if (st && m_valid) begin
              m_skid.push_back({w_instr, w_pc4}); m_inflight = 0;
            end else begin
              m_instr = w_instr; m_pc4 = w_pc4; m_valid = 1; loaded = 1; m_addr = w_pc4;
            end
          end
        end
      end else if (m_skid.size() != 0) begin
        if (!st) begin
          e = m_skid.pop_front();
          m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1; loaded = 1;
        end
      end else begin
        m_inflight = 1; m_addr = m_pc;
      end
      if (!loaded && !st) begin m_instr = 32'h0; m_valid = 0; end
    end
    @(posedge clk);
    #1;
    check("imem_req", {31'd0, imem_req}, {31'd0, m_inflight});
    if (m_inflight) check("imem_addr", imem_addr, m_addr);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
  endtask

  task automatic idle_step(input bit st, input bit rd);
    step(st, rd, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h55, 1, 32'h66, 1);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_pc4", if_id_pc4, 32'd0);

    // Startup with ready tied high
    idle_step(0, 1);
    check("start_req", {31'd0, imem_req}, 32'd1);
    check("start_addr", imem_addr, 32'h0);
    idle_step(0, 1);
    check("first_instr", if_id_instr, 32'h0);
    check("first_pc4", if_id_pc4, 32'h4);
    check("first_valid", {31'd0, if_id_valid}, 32'd1);
    idle_step(0, 1);
    check("second_pc4", if_id_pc4, 32'h8);
    idle_step(0, 1);
    check("third_pc4", if_id_pc4, 32'hC);

    // Stall with a returning word: skid captures 0xC, IF/ID holds
    idle_step(1, 1);
    check("stall_hold_pc4", if_id_pc4, 32'hC);
    check("stall_req_drop", {31'd0, imem_req}, 32'd0);
    idle_step(1, 1);
    check("stall_hold2_pc4", if_id_pc4, 32'hC);
    idle_step(0, 1);
    check("skid_pc4", if_id_pc4, 32'h10);
    check("skid_instr", if_id_instr, 32'hC);
    check("skid_valid", {31'd0, if_id_valid}, 32'd1);
    idle_step(0, 1);
    check("resume_addr", imem_addr, 32'h10);
    check("resume_bubble", {31'd0, if_id_valid}, 32'd0);

    // Three-cycle memory latency
    hold_a = imem_addr;
    idle_step(0, 0);
    check("lat_addr1", imem_addr, hold_a);
    check("lat_valid1", {31'd0, if_id_valid}, 32'd0);
    idle_step(0, 0);
    check("lat_addr2", imem_addr, hold_a);
    idle_step(0, 1);
    check("lat_pc4", if_id_pc4, hold_a + 32'd4);
    check("lat_valid", {31'd0, if_id_valid}, 32'd1);

    // Branch while a fetch is outstanding
    step(0, 0, 1, 32'h100, 0, 32'h0, 0);
    check("br_flush_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_flush_instr", if_id_instr, 32'd0);
    check("br_keep_req", {31'd0, imem_req}, 32'd1);
    idle_step(0, 0);
    idle_step(0, 1);
    check("br_drop_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_new_addr", imem_addr, 32'h100);
    idle_step(0, 1);
    check("br_pc4", if_id_pc4, 32'h104);

    // Branch and jump together, under stall
    step(1, 1, 1, 32'h40, 1, 32'h80, 0);
    check("bj_flush_valid", {31'd0, if_id_valid}, 32'd0);
    idle_step(1, 1);
    check("bj_addr", imem_addr, 32'h40);
    idle_step(0, 1);
    check("bj_pc4", if_id_pc4, 32'h44);

    // Unaligned-free wrap at the top of the address space
    step(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    idle_step(0, 1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    idle_step(0, 1);
    check("wrap_pc4", if_id_pc4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Reset while the skid buffer is full
    idle_step(1, 1);
    check("full_req", {31'd0, imem_req}, 32'd0);
    step(1, 1, 0, 0, 0, 0, 1);
    check("full_rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("full_rst_pc4", if_id_pc4, 32'd0);
    idle_step(0, 1);
    check("post_rst_addr", imem_addr, 32'h0);

    // Randomized traffic against the model
    scramble = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bta, jta;
      bta = $urandom;
      jta = $urandom;
      if ($urandom_range(0, 3) != 0) begin bta[1:0] = 2'b00; jta[1:0] = 2'b00; end
      if ($urandom_range(0, 15) == 0) bta = 32'hFFFF_FFFC;
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 5, bta, $urandom_range(0, 99) < 5, jta,
           $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
